// File: rtl/upsp_frame_ctrl.sv
// Frame controller for the upsampler: passes the input stream to the upsampler and
// the upsampler results to the output stream, counting beats per frame and reporting status.
module upsp_frame_ctrl #(
  parameter int IMG_W           = 960,
  parameter int IMG_H           = 540,
  parameter int SCALE           = 4,
  parameter int CRF_DATA_WIDTH  = 32,
  parameter int UPSP_DATA_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [CRF_DATA_WIDTH-1:0]  UPSTR,
  output logic [CRF_DATA_WIDTH-1:0]  UPENDR,
  input  logic                       upendr_clr,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic [UPSP_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                       s_axis_tlast,
  input  logic                       upsp_ac_rd,
  output logic                       ac_upsp_rvalid,
  output logic [UPSP_DATA_WIDTH-1:0] ac_upsp_rdata,
  input  logic                       upsp_ac_wrt,
  input  logic [UPSP_DATA_WIDTH-1:0] upsp_ac_wdata,
  output logic                       ac_upsp_wready,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [UPSP_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                       m_axis_tlast,
  output logic                       interrupt_updone
);

  localparam int IN_TOTAL  = IMG_W * IMG_H;
  localparam int OUT_TOTAL = IN_TOTAL * SCALE * SCALE;
  localparam int CW        = $clog2(OUT_TOTAL + 1);
  localparam logic [CW-1:0] IN_T  = CW'(IN_TOTAL);
  localparam logic [CW-1:0] OUT_T = CW'(OUT_TOTAL);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state, state_nx;
  logic [CW-1:0] in_cnt, out_cnt, in_cnt_inc, out_cnt_inc;
  logic          start_q, armed, done_r, err_r;
  logic          run, out_act, in_xfer, out_xfer, start_edge, go;
  logic          tlast_bad, out_fin, early_fin;
  logic          unused_upstr;

  assign unused_upstr = ^UPSTR[CRF_DATA_WIDTH-1:1];

  assign run     = (state == S_RUN);
  assign out_act = (state == S_RUN) || (state == S_DRAIN);

  assign s_axis_tready  = run & upsp_ac_rd;
  assign ac_upsp_rvalid = run & s_axis_tvalid;
  assign ac_upsp_rdata  = run ? s_axis_tdata : '0;

  assign m_axis_tvalid  = out_act & upsp_ac_wrt;
  assign m_axis_tdata   = out_act ? upsp_ac_wdata : '0;
  assign ac_upsp_wready = out_act & m_axis_tready;
  assign m_axis_tlast   = m_axis_tvalid && (out_cnt == OUT_T - 1'b1);

  assign interrupt_updone = (state == S_DONE);
  assign UPENDR = {{(CRF_DATA_WIDTH-3){1'b0}}, err_r, out_act, done_r};

  assign in_xfer     = s_axis_tvalid & s_axis_tready;
  assign out_xfer    = upsp_ac_wrt & ac_upsp_wready;
  assign in_cnt_inc  = in_cnt + CW'(in_xfer);
  assign out_cnt_inc = out_cnt + CW'(out_xfer);

  // After reset the start level must be seen low once, so a level held
  // across reset cannot look like a fresh edge.
  assign start_edge = UPSTR[0] & ~start_q & armed;
  assign go         = (state == S_IDLE) & start_edge;

  assign tlast_bad = in_xfer & (s_axis_tlast != (in_cnt == IN_T - 1'b1));
  assign out_fin   = out_xfer & (out_cnt_inc == OUT_T);
  assign early_fin = out_fin & (in_cnt_inc != IN_T);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start_edge) state_nx = S_RUN;
      S_RUN: begin
        if (out_fin)                 state_nx = S_DONE;
        else if (in_cnt_inc == IN_T) state_nx = S_DRAIN;
      end
      S_DRAIN: if (out_fin) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      in_cnt  <= '0;
      out_cnt <= '0;
      start_q <= 1'b0;
      armed   <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state   <= state_nx;
      start_q <= UPSTR[0];
      armed   <= armed | ~UPSTR[0];
      if (go) begin
        in_cnt  <= '0;
        out_cnt <= '0;
      end else begin
        in_cnt  <= in_cnt_inc;
        out_cnt <= out_cnt_inc;
      end
      // done set in the DONE cycle beats a coincident clear
      if (state == S_DONE)  done_r <= 1'b1;
      else if (go)          done_r <= 1'b0;
      else if (upendr_clr)  done_r <= 1'b0;
      if (go)                          err_r <= 1'b0;
      else if (tlast_bad || early_fin) err_r <= 1'b1;
      else if (upendr_clr)             err_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_upsp_frame_ctrl.sv
// Randomized self-checking bench for upsp_frame_ctrl on a 4x2 frame, scale 2.
module tb_upsp_frame_ctrl;
  localparam int IN_T  = 8;
  localparam int OUT_T = 32;
  localparam int RATIO = OUT_T / IN_T;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] UPSTR;
  logic [31:0] UPENDR;
  logic        upendr_clr;
  logic        s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [31:0] s_axis_tdata;
  logic        upsp_ac_rd, ac_upsp_rvalid;
  logic [31:0] ac_upsp_rdata;
  logic        upsp_ac_wrt, ac_upsp_wready;
  logic [31:0] upsp_ac_wdata;
  logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [31:0] m_axis_tdata;
  logic        interrupt_updone;

  upsp_frame_ctrl #(.IMG_W(4), .IMG_H(2), .SCALE(2), .CRF_DATA_WIDTH(32), .UPSP_DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .UPSTR(UPSTR), .UPENDR(UPENDR), .upendr_clr(upendr_clr),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .s_axis_tlast(s_axis_tlast), .upsp_ac_rd(upsp_ac_rd), .ac_upsp_rvalid(ac_upsp_rvalid),
    .ac_upsp_rdata(ac_upsp_rdata), .upsp_ac_wrt(upsp_ac_wrt), .upsp_ac_wdata(upsp_ac_wdata),
    .ac_upsp_wready(ac_upsp_wready), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast), .interrupt_updone(interrupt_updone)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // per-frame observations
  int n_in, n_out, tlast_cnt, tlast_at, irq_cnt, irq_cyc, last_out_cyc, pass_err, busy_cyc, in_at_last;
  bit timeout;
  logic [31:0] in_data [IN_T];
  logic [101:0] obs;

  function automatic logic [31:0] exp_status(input int tlast_beat, input int inputs_at_final);
    bit err;
    err = (tlast_beat != IN_T) || (inputs_at_final < IN_T);
    return {29'd0, err, 1'b0, 1'b1};
  endfunction

  task automatic idle_inputs();
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0; upsp_ac_rd = 1'b0;
    upsp_ac_wrt = 1'b0; upsp_ac_wdata = '0; m_axis_tready = 1'b0; upendr_clr = 1'b0;
  endtask

  task automatic busy_inputs();
    s_axis_tvalid = 1'b1; s_axis_tdata = $urandom; s_axis_tlast = 1'b1; upsp_ac_rd = 1'b1;
    upsp_ac_wrt = 1'b1; upsp_ac_wdata = $urandom; m_axis_tready = 1'b1;
  endtask

  task automatic sample_outputs();
    obs = {UPENDR, s_axis_tready, ac_upsp_rvalid, ac_upsp_rdata, ac_upsp_wready,
           m_axis_tvalid, m_axis_tdata, m_axis_tlast, interrupt_updone};
  endtask

  task automatic start_pulse();
    UPSTR = 32'h0;
    @(posedge clk); #1;
    UPSTR = 32'h1;
  endtask

  // Acts as source, upsampler and sink; the upsampler emits RATIO outputs per
  // accepted input unless 'early' lets it run ahead of a stalled source.
  task automatic drive_frame(input int tlast_beat, input bit bp, input bit early,
                             input int stop_after, input bit drain_toggle, input bit clr_at_done);
    int cyc, in_idx, out_idx, post, tog;
    bit in_x, out_x;
    n_in = 0; n_out = 0; tlast_cnt = 0; tlast_at = 0; irq_cnt = 0; irq_cyc = -1;
    last_out_cyc = -1; pass_err = 0; busy_cyc = 0; in_at_last = 0; timeout = 0;
    for (int i = 0; i < IN_T; i++) in_data[i] = $urandom;
    cyc = 0; in_idx = 0; out_idx = 0; post = 0; tog = 0;
    forever begin
      s_axis_tvalid = !early && (in_idx < IN_T) && (bp ? 1'($urandom_range(0, 1)) : 1'b1);
      s_axis_tdata  = (in_idx < IN_T) ? in_data[in_idx] : $urandom;
      s_axis_tlast  = (in_idx + 1 == tlast_beat);
      upsp_ac_rd    = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      upsp_ac_wrt   = (out_idx < OUT_T) && (early || out_idx < RATIO * in_idx) &&
                      (bp ? 1'($urandom_range(0, 1)) : 1'b1);
      upsp_ac_wdata = $urandom;
      m_axis_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      in_x  = s_axis_tvalid && s_axis_tready;
      out_x = m_axis_tvalid && m_axis_tready;
      if (out_x !== (upsp_ac_wrt && ac_upsp_wready)) pass_err++;
      if (out_x && m_axis_tdata !== upsp_ac_wdata) pass_err++;
      if (in_x && (ac_upsp_rvalid !== 1'b1 || ac_upsp_rdata !== s_axis_tdata)) pass_err++;
      if (m_axis_tlast && !m_axis_tvalid) pass_err++;
      if (UPENDR[1]) busy_cyc++;
      if (interrupt_updone) begin irq_cnt++; irq_cyc = cyc; end
      if (in_x) in_idx++;
      if (out_x) begin
        out_idx++;
        last_out_cyc = cyc;
        in_at_last = in_idx;
        if (m_axis_tlast) begin tlast_cnt++; tlast_at = out_idx; end
      end
      cyc++;
      @(posedge clk); #1;
      upendr_clr = clr_at_done && out_x && (out_idx == OUT_T);
      if (drain_toggle) begin
        if (tog == 0 && in_idx == IN_T && out_idx >= OUT_T - 4) begin UPSTR = 32'h0; tog = 1; end
        else if (tog == 1) begin UPSTR = 32'h1; tog = 2; end
      end
      if (irq_cnt > 0) post++;
      if (post >= 3) break;
      if (stop_after > 0 && out_idx >= stop_after) break;
      if (cyc > 2000) begin timeout = 1; break; end
    end
    n_in = in_idx; n_out = out_idx;
    s_axis_tvalid = 1'b0; upsp_ac_wrt = 1'b0; upendr_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; UPSTR = 32'h0;
    busy_inputs();
    @(negedge clk);
    sample_outputs();
    tests++;
    if (obs !== '0) begin fails++; $display("FAIL reset_outputs: got %h want 0", obs); end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    sample_outputs();
    tests++;
    if (obs !== '0) begin fails++; $display("FAIL idle_outputs: got %h want 0", obs); end
    @(posedge clk); #1 idle_inputs();
  endtask

  task automatic test_nominal();
    start_pulse();
    drive_frame(IN_T, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    tests++;
    if (timeout || n_out != OUT_T || n_in != IN_T) begin
      fails++; $display("FAIL nominal_counts: got in=%0d out=%0d to=%0d want in=%0d out=%0d", n_in, n_out, timeout, IN_T, OUT_T);
    end
    tests++;
    if (tlast_cnt != 1 || tlast_at != OUT_T) begin
      fails++; $display("FAIL nominal_tlast: got cnt=%0d at=%0d want cnt=1 at=%0d", tlast_cnt, tlast_at, OUT_T);
    end
    tests++;
    if (irq_cnt != 1 || irq_cyc != last_out_cyc + 1) begin
      fails++; $display("FAIL nominal_irq: got cnt=%0d cyc=%0d want cnt=1 cyc=%0d", irq_cnt, irq_cyc, last_out_cyc + 1);
    end
    tests++;
    if (pass_err != 0) begin fails++; $display("FAIL nominal_passthru: got %0d errors want 0", pass_err); end
    tests++;
    if (busy_cyc < OUT_T) begin fails++; $display("FAIL nominal_busy: got %0d busy cycles want >= %0d", busy_cyc, OUT_T); end
    tests++;
    if (UPENDR !== exp_status(IN_T, in_at_last)) begin
      fails++; $display("FAIL nominal_status: got %h want %h", UPENDR, exp_status(IN_T, in_at_last));
    end
  endtask

  task automatic test_backpressure();
    for (int f = 0; f < 3; f++) begin
      start_pulse();
      drive_frame(IN_T, 1'b1, 1'b0, 0, 1'b0, 1'b0);
      tests++;
      if (timeout || n_out != OUT_T || n_in != IN_T || pass_err != 0) begin
        fails++; $display("FAIL bp_counts[%0d]: got in=%0d out=%0d perr=%0d to=%0d want in=%0d out=%0d perr=0", f, n_in, n_out, pass_err, timeout, IN_T, OUT_T);
      end
      tests++;
      if (tlast_cnt != 1 || tlast_at != OUT_T || irq_cnt != 1 || irq_cyc != last_out_cyc + 1) begin
        fails++; $display("FAIL bp_done[%0d]: got tlast=%0d@%0d irq=%0d@%0d want 1@%0d 1@%0d", f, tlast_cnt, tlast_at, irq_cnt, irq_cyc, OUT_T, last_out_cyc + 1);
      end
      tests++;
      if (UPENDR !== exp_status(IN_T, in_at_last)) begin
        fails++; $display("FAIL bp_status[%0d]: got %h want %h", f, UPENDR, exp_status(IN_T, in_at_last));
      end
    end
  endtask

  task automatic test_tlast_error();
    int beats [2] = '{3, 0};
    foreach (beats[k]) begin
      start_pulse();
      drive_frame(beats[k], 1'b1, 1'b0, 0, 1'b0, 1'b0);
      tests++;
      if (timeout || n_out != OUT_T || irq_cnt != 1) begin
        fails++; $display("FAIL tlast_err_frame[%0d]: got out=%0d irq=%0d want out=%0d irq=1", k, n_out, irq_cnt, OUT_T);
      end
      tests++;
      if (UPENDR !== exp_status(beats[k], in_at_last)) begin
        fails++; $display("FAIL tlast_err_status[%0d]: got %h want %h", k, UPENDR, exp_status(beats[k], in_at_last));
      end
    end
  endtask

  task automatic test_early_finish();
    start_pulse();
    drive_frame(IN_T, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    tests++;
    if (timeout || n_out != OUT_T || n_in != 0 || irq_cnt != 1 || irq_cyc != last_out_cyc + 1) begin
      fails++; $display("FAIL early_frame: got in=%0d out=%0d irq=%0d want in=0 out=%0d irq=1", n_in, n_out, irq_cnt, OUT_T);
    end
    tests++;
    if (UPENDR !== exp_status(IN_T, in_at_last)) begin
      fails++; $display("FAIL early_status: got %h want %h", UPENDR, exp_status(IN_T, in_at_last));
    end
  endtask

  task automatic test_reset_midframe();
    int bad;
    start_pulse();
    drive_frame(IN_T, 1'b0, 1'b0, 10, 1'b0, 1'b0);
    busy_inputs();
    rst_n = 1'b0;
    #1 sample_outputs();
    tests++;
    if (obs !== '0) begin fails++; $display("FAIL midreset_outputs: got %h want 0", obs); end
    bad = 0;
    repeat (3) begin @(negedge clk); if (interrupt_updone) bad++; end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (s_axis_tready || m_axis_tvalid || interrupt_updone || UPENDR != 0) bad++;
      @(posedge clk); #1 busy_inputs();
    end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL held_start: got %0d active cycles want 0", bad); end
    idle_inputs();
    start_pulse();
    drive_frame(IN_T, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    tests++;
    if (timeout || n_out != OUT_T || tlast_at != OUT_T || UPENDR !== 32'h1) begin
      fails++; $display("FAIL restart_frame: got out=%0d tlast@%0d st=%h want out=%0d tlast@%0d st=1", n_out, tlast_at, UPENDR, OUT_T, OUT_T);
    end
  endtask

  task automatic test_busy_start_clear();
    start_pulse();
    drive_frame(IN_T, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    tests++;
    if (timeout || n_out != OUT_T || tlast_cnt != 1 || tlast_at != OUT_T || irq_cnt != 1) begin
      fails++; $display("FAIL drain_start: got out=%0d tlast=%0d@%0d irq=%0d want out=%0d tlast=1@%0d irq=1", n_out, tlast_cnt, tlast_at, irq_cnt, OUT_T, OUT_T);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if (UPENDR !== 32'h1) begin fails++; $display("FAIL no_restart: got %h want 1", UPENDR); end
    @(posedge clk); #1 upendr_clr = 1'b1;
    @(posedge clk); #1 upendr_clr = 1'b0;
    @(negedge clk);
    tests++;
    if (UPENDR !== 32'h0) begin fails++; $display("FAIL clear_status: got %h want 0", UPENDR); end
  endtask

  task automatic test_back_to_back();
    start_pulse();
    drive_frame(IN_T, 1'b1, 1'b0, 0, 1'b0, 1'b1);
    tests++;
    if (timeout || n_out != OUT_T || UPENDR !== 32'h1) begin
      fails++; $display("FAIL clr_at_done: got out=%0d st=%h want out=%0d st=1", n_out, UPENDR, OUT_T);
    end
    start_pulse();
    drive_frame(IN_T, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    tests++;
    if (timeout || n_out != OUT_T || tlast_at != OUT_T || irq_cnt != 1 || UPENDR !== exp_status(IN_T, in_at_last)) begin
      fails++; $display("FAIL b2b_frame: got out=%0d tlast@%0d irq=%0d st=%h want out=%0d tlast@%0d irq=1 st=%h", n_out, tlast_at, irq_cnt, UPENDR, OUT_T, OUT_T, exp_status(IN_T, in_at_last));
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_nominal();
    test_backpressure();
    test_tlast_error();
    test_early_finish();
    test_reset_midframe();
    test_busy_start_clear();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
